// File: rtl/fios_pe_row.sv
// Sequenced FIOS Montgomery row engine: one outer iteration t <- (t + a*b + m*p) / 2^W.
// Optional FIOS_PE_ROW_M_OUT_EN exposes the per-row quotient digit m on m_o/m_valid_o.
module fios_pe_row #(
  parameter int WORD_WIDTH = 17,
  parameter int NUM_WORDS  = 4,
  parameter int M_LATENCY  = 3
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] p_prime_0_i,
  input  logic [WORD_WIDTH-1:0] t_top_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WORD_WIDTH-1:0] b_i,
  input  logic [WORD_WIDTH-1:0] p_i,
  input  logic [WORD_WIDTH-1:0] t_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WORD_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic [1:0]            out_carry_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef FIOS_PE_ROW_M_OUT_EN
  ,
  output logic [WORD_WIDTH-1:0] m_o,
  output logic                  m_valid_o
`endif
);

  localparam int W  = WORD_WIDTH;
  localparam int SW = 2 * W + 1;  // t + a*b + m*p + C never reaches 2^(2W+1)
  localparam int BW = $clog2(NUM_WORDS);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FIRST  = 3'd1;
  localparam logic [2:0] ST_M_WAIT = 3'd2;
  localparam logic [2:0] ST_ROW    = 3'd3;
  localparam logic [2:0] ST_FINAL  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [2:0]    wait_cnt_q, wait_cnt_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [W:0]    c_q, c_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic [1:0]    out_carry_q, out_carry_d;
  logic          done_q, done_d;

  logic [W-1:0] a_q, pp0_q, t_top_q, t0_q, b0_q, p0_q;
  logic [M_LATENCY-1:0][W-1:0] m_pipe_q;

  logic out_free, in_fire, wait_last;
  logic [W-1:0] s_lo, m_new, m_cur;
  logic [W-1:0] op_t, op_b, op_p;
  logic [W:0]   op_c;
  logic [SW-1:0] row_sum;
  logic [W+1:0]  fin_sum;

  assign out_free   = !out_valid_q || out_ready_i;
  assign in_ready_o = ((state_q == ST_FIRST) || (state_q == ST_ROW)) && out_free;
  assign in_fire    = in_valid_i && in_ready_o;
  assign wait_last  = (state_q == ST_M_WAIT) && (wait_cnt_q == 3'(M_LATENCY - 1));

  // m only needs the low word of t_0 + a*b_0, so it is computed modulo 2^W.
  assign s_lo  = t_i + a_q * b_i;
  assign m_new = s_lo * pp0_q;
  assign m_cur = m_pipe_q[M_LATENCY-1];

  // The shared datapath replays beat 0 during M_WAIT to produce the first carry.
  always_comb begin
    op_t = t_i;
    op_b = b_i;
    op_p = p_i;
    op_c = c_q;
    if (state_q == ST_M_WAIT) begin
      op_t = t0_q;
      op_b = b0_q;
      op_p = p0_q;
      op_c = '0;
    end
  end

  assign row_sum = SW'(op_t) + SW'(a_q) * SW'(op_b) + SW'(m_cur) * SW'(op_p) + SW'(op_c);
  assign fin_sum = (W + 2)'(t_top_q) + (W + 2)'(c_q);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    beat_d      = beat_q;
    c_d         = c_q;
    out_valid_d = out_valid_q && !out_ready_i;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q && !out_ready_i;
    out_carry_d = out_carry_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_FIRST;
      end
      ST_FIRST: begin
        if (in_fire) begin
          state_d    = ST_M_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_M_WAIT: begin
        if (wait_last) begin
          state_d = ST_ROW;
          beat_d  = BW'(1);
          c_d     = row_sum[2*W:W];
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      ST_ROW: begin
        if (in_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = row_sum[W-1:0];
          c_d         = row_sum[2*W:W];
          if (beat_q == BW'(NUM_WORDS - 1)) state_d = ST_FINAL;
          else                              beat_d  = beat_q + BW'(1);
        end
      end
      ST_FINAL: begin
        if (!out_last_q && out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = fin_sum[W-1:0];
          out_last_d  = 1'b1;
          out_carry_d = fin_sum[W+1:W];
        end else if (out_last_q && out_ready_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      beat_q      <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_carry_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      beat_q      <= beat_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_carry_q <= out_carry_d;
      done_q      <= done_d;
    end
  end

  // NOTE: the m pipeline is reset as well, so m reads as zero after reset rather than stale data.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_q      <= '0;
      pp0_q    <= '0;
      t_top_q  <= '0;
      t0_q     <= '0;
      b0_q     <= '0;
      p0_q     <= '0;
      m_pipe_q <= '0;
    end else begin
      if (state_q == ST_IDLE && start_i) begin
        a_q     <= a_i;
        pp0_q   <= p_prime_0_i;
        t_top_q <= t_top_i;
      end
      if (state_q == ST_FIRST && in_fire) begin
        t0_q        <= t_i;
        b0_q        <= b_i;
        p0_q        <= p_i;
        m_pipe_q[0] <= m_new;
      end
      if (state_q == ST_M_WAIT) begin
        for (int i = 1; i < M_LATENCY; i++) m_pipe_q[i] <= m_pipe_q[i-1];
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_carry_o = out_carry_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;

`ifdef FIOS_PE_ROW_M_OUT_EN
  assign m_o       = m_cur;
  assign m_valid_o = wait_last;
`endif

endmodule
